// File: rtl/logic_op_sequencer_pkg.sv
// Shared encodings for the nibble-serial logic operation sequencer:
// ALU op codes, gate chip selects, the NOT mask and FSM states.
package logic_op_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOT = 2'b11
    } op_e;

    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_OR  = 2'b01;
    localparam logic [1:0] SEL_XOR = 2'b10;

    localparam logic [3:0] NOT_MASK = 4'hF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/logic_op_sequencer.sv
// Drives a shared 4-bit 2-input gate chip one nibble at a time, waiting SETTLE
// cycles per nibble, and assembles the full-width result plus a zero flag.
module logic_op_sequencer
    import logic_op_sequencer_pkg::*;
#(
    parameter int NIBBLES = 2,
    parameter int SETTLE  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 zero,
    output logic [3:0]           gate_a,
    output logic [3:0]           gate_b,
    output logic [1:0]           gate_sel,
    input  logic [3:0]           gate_y
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
    localparam logic [1:0] LAST_IDX   = 2'(NIBBLES - 1);

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [4*NIBBLES-1:0] a_q, a_d;
    logic [4*NIBBLES-1:0] b_q, b_d;
    logic [1:0]           idx_q, idx_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [4*NIBBLES-1:0] result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_AND;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    // Capture happens on the last settle cycle of each nibble; the zero flag
    // is taken from the result including the nibble captured on that edge.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op_e'(op);
                    idx_d   = '0;
                    cnt_d   = SETTLE_CNT;
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx_q == 2'(i)) begin
                            result_d[4*i +: 4] = gate_y;
                        end
                    end
                    idx_d = idx_q + 2'd1;
                    cnt_d = SETTLE_CNT;
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        zero_d  = (result_d == '0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOT A is realised on the XOR chip with the B inputs tied high.
    always_comb begin
        gate_a   = 4'h0;
        gate_b   = 4'h0;
        gate_sel = SEL_AND;
        if (state_q == RUN) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx_q == 2'(i)) begin
                    gate_a = a_q[4*i +: 4];
                    gate_b = b_q[4*i +: 4];
                end
            end
            case (op_q)
                OP_AND:  gate_sel = SEL_AND;
                OP_OR:   gate_sel = SEL_OR;
                OP_XOR:  gate_sel = SEL_XOR;
                default: begin
                    gate_sel = SEL_XOR;
                    gate_b   = NOT_MASK;
                end
            endcase
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign result = result_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Runs three sequencer configurations (2x1, 2x3, 4x1 nibbles x settle) side by
// side from one stimulus stream, each checked every cycle against a timeline model.
module tb_logic_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [15:0] aBus;
    logic [15:0] bBus;
    logic        checkEn = 1'b0;

    int nChecks = 0;
    int nFail   = 0;

    logic [2:0]  busyVec, doneVec, zeroVec;
    logic [15:0] resVec [3];
    logic [3:0]  gaVec  [3];
    logic [3:0]  gbVec  [3];
    logic [1:0]  gsVec  [3];

    always #5 clk = ~clk;

    function automatic logic [15:0] opFunc(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~x;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int N = (g == 2) ? 4 : 2;
        localparam int S = (g == 1) ? 3 : 1;

        logic           busy, done, zero;
        logic [4*N-1:0] result;
        logic [3:0]     gA, gB, gY;
        logic [1:0]     gSel;

        // Gate resource: the 08/32/86 chips behind the gate_sel mux.
        always_comb begin
            case (gSel)
                2'b00:   gY = gA & gB;
                2'b01:   gY = gA | gB;
                2'b10:   gY = gA ^ gB;
                default: gY = 4'h0;
            endcase
        end

        logic_op_sequencer #(.NIBBLES(N), .SETTLE(S)) dut (
            .clk      (clk),
            .reset    (reset),
            .start    (start),
            .op       (op),
            .a        (aBus[4*N-1:0]),
            .b        (bBus[4*N-1:0]),
            .busy     (busy),
            .done     (done),
            .result   (result),
            .zero     (zero),
            .gate_a   (gA),
            .gate_b   (gB),
            .gate_sel (gSel),
            .gate_y   (gY)
        );

        assign busyVec[g] = busy;
        assign doneVec[g] = done;
        assign zeroVec[g] = zero;
        assign resVec[g]  = 16'(result);
        assign gaVec[g]   = gA;
        assign gbVec[g]   = gB;
        assign gsVec[g]   = gSel;

        bit          mBusy = 1'b0, mDone = 1'b0, mZero = 1'b0;
        int          mPhase = 0;
        logic [15:0] mA = '0, mB = '0, mRes = '0;
        logic [1:0]  mOp = '0;

        // Model: a sequence is N*S edges long; nibble k lands on edge (k+1)*S.
        always @(posedge clk) begin : model
            int          nib;
            logic [15:0] full;
            if (reset) begin
                mBusy = 0; mDone = 0; mZero = 0; mRes = '0; mPhase = 0;
            end else if (!mBusy) begin
                mDone = 0;
                if (start) begin
                    mA = aBus; mB = bBus; mOp = op; mPhase = 0; mBusy = 1;
                end
            end else begin
                if ((mPhase + 1) % S == 0) begin
                    nib  = mPhase / S;
                    full = opFunc(mOp, mA, mB);
                    mRes[4*nib +: 4] = full[4*nib +: 4];
                end
                mPhase++;
                if (mPhase == N * S) begin
                    mBusy = 0;
                    mDone = 1;
                    mZero = (mRes[4*N-1:0] == '0);
                end
            end
        end

        always @(negedge clk) begin : cmp
            int         nib;
            logic [3:0] eGa, eGb;
            logic [1:0] eSel;
            if (checkEn) begin
                eGa = 4'h0; eGb = 4'h0; eSel = 2'b00;
                if (mBusy) begin
                    nib  = mPhase / S;
                    eGa  = mA[4*nib +: 4];
                    eGb  = (mOp == 2'b11) ? 4'hF : mB[4*nib +: 4];
                    eSel = (mOp == 2'b11) ? 2'b10 : mOp;
                end
                checkOutput($sformatf("cfg%0d.busy", g), 32'(busy), 32'(mBusy));
                checkOutput($sformatf("cfg%0d.done", g), 32'(done), 32'(mDone));
                checkOutput($sformatf("cfg%0d.zero", g), 32'(zero), 32'(mZero));
                checkOutput($sformatf("cfg%0d.result", g), 32'(result), 32'(mRes[4*N-1:0]));
                checkOutput($sformatf("cfg%0d.gate_a", g), 32'(gA), 32'(eGa));
                checkOutput($sformatf("cfg%0d.gate_b", g), 32'(gB), 32'(eGb));
                checkOutput($sformatf("cfg%0d.gate_sel", g), 32'(gSel), 32'(eSel));
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        start = 1'b1; op = o; aBus = x; bBus = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int g, output int k);
        k = 0;
        while (!doneVec[g] && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!doneVec[g]) checkOutput($sformatf("cfg%0d.doneTimeout", g), 32'(0), 32'(1));
    endtask

    task automatic waitIdle();
        int k = 0;
        while (busyVec != 3'b000 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busyVec != 3'b000) checkOutput("idleTimeout", 32'(busyVec), 32'(0));
        @(negedge clk);
    endtask

    initial begin
        int k;
        reset = 1'b1; start = 1'b0; op = 2'b00; aBus = '0; bBus = '0;
        repeat (2) @(negedge clk);
        checkEn = 1'b1;
        checkOutput("reset.busy", 32'(busyVec), 32'(0));
        checkOutput("reset.result0", 32'(resVec[0]), 32'(0));
        checkOutput("reset.gate_sel0", 32'(gsVec[0]), 32'(0));
        reset = 1'b0;
        @(negedge clk);

        // AND with defaults
        applyStimulus(2'b00, 16'h00C3, 16'h00A5);
        checkOutput("and.gate_a0", 32'(gaVec[0]), 32'h3);
        @(negedge clk);
        checkOutput("and.gate_a1", 32'(gaVec[0]), 32'hC);
        waitDone(0, k);
        checkOutput("and.result", 32'(resVec[0]), 32'h81);
        checkOutput("and.zero", 32'(zeroVec[0]), 32'h0);
        waitIdle();

        // NOT and zero flag
        applyStimulus(2'b11, 16'h00FF, 16'h0000);
        checkOutput("not.gate_b", 32'(gbVec[0]), 32'hF);
        checkOutput("not.gate_sel", 32'(gsVec[0]), 32'h2);
        waitDone(0, k);
        checkOutput("not.result", 32'(resVec[0]), 32'h00);
        checkOutput("not.zero", 32'(zeroVec[0]), 32'h1);
        waitIdle();
        applyStimulus(2'b11, 16'h000F, 16'h0000);
        waitDone(0, k);
        checkOutput("not2.result", 32'(resVec[0]), 32'hF0);
        waitIdle();

        // Settle timing on the SETTLE=3 instance
        applyStimulus(2'b01, 16'h0012, 16'h0040);
        waitDone(1, k);
        checkOutput("settle.edges", 32'(k), 32'(6));
        checkOutput("settle.result", 32'(resVec[1]), 32'h52);
        waitIdle();

        // Busy rejection, then start held through the done cycle
        applyStimulus(2'b10, 16'h0055, 16'h00FF);
        start = 1'b1; op = 2'b00; aBus = 16'h0000; bBus = 16'h0000;
        @(negedge clk);
        start = 1'b0;
        waitDone(0, k);
        checkOutput("busy.result", 32'(resVec[0]), 32'hAA);
        waitIdle();
        start = 1'b1; op = 2'b00; aBus = 16'h00F0; bBus = 16'h003C;
        waitDone(0, k);
        @(negedge clk);
        checkOutput("b2b.busy", 32'(busyVec[0]), 32'h1);
        start = 1'b0;
        waitIdle();
        checkOutput("b2b.result", 32'(resVec[0]), 32'h30);

        // Reset at the first capture edge
        applyStimulus(2'b00, 16'h00FF, 16'h00FF);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst.busy", 32'(busyVec[0]), 32'h0);
        checkOutput("rst.result", 32'(resVec[0]), 32'h0);
        checkOutput("rst.gate_a", 32'(gaVec[0]), 32'h0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst.noDone", 32'(doneVec[0]), 32'h0);
        end

        // Four nibbles on the NIBBLES=4 instance
        applyStimulus(2'b10, 16'h1234, 16'hFFFF);
        checkOutput("n4.gate_a0", 32'(gaVec[2]), 32'h4);
        @(negedge clk);
        checkOutput("n4.gate_a1", 32'(gaVec[2]), 32'h3);
        @(negedge clk);
        checkOutput("n4.gate_a2", 32'(gaVec[2]), 32'h2);
        @(negedge clk);
        checkOutput("n4.gate_a3", 32'(gaVec[2]), 32'h1);
        @(negedge clk);
        checkOutput("n4.done", 32'(doneVec[2]), 32'h1);
        checkOutput("n4.result", 32'(resVec[2]), 32'hEDCB);
        waitIdle();

        // Random traffic, including occasional resets
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            op    = 2'($urandom_range(0, 3));
            aBus  = 16'($urandom);
            bBus  = 16'($urandom);
            reset = ($urandom_range(0, 63) == 0);
        end
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        waitIdle();
        checkEn = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
